// File: rtl/mask_gen_pkg.sv
// Shared types and defaults for the mask generator sequencing controller.
package mask_gen_pkg;

  localparam int DEF_ROWS    = 480;
  localparam int DEF_PAT_LEN = 32;

  typedef enum logic [1:0] {
    SLIDE_R = 2'b00,
    SLIDE_L = 2'b01,
    RANDOM  = 2'b10,
    REPEAT  = 2'b11
  } mask_type_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GEN_RST    = 3'd1,
    LOAD       = 3'd2,
    WAIT_FRAME = 3'd3,
    ROW_WAIT   = 3'd4,
    ROW_RUN    = 3'd5
  } state_e;

endpackage

// File: rtl/mask_pattern_serializer.sv
// Parallel-in, MSB-first serial-out shift register with a bit counter that
// flags the cycle presenting the final bit.
module mask_pattern_serializer
  import mask_gen_pkg::*;
#(
  parameter int PAT_LEN = DEF_PAT_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [PAT_LEN-1:0] data_i,
  input  logic               shift_i,
  output logic               bit_o,
  output logic               done_o
);

  localparam int CW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  logic [PAT_LEN-1:0] sr_q;
  logic [CW-1:0]      cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= data_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= sr_q << 1;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign bit_o  = sr_q[PAT_LEN-1];
  assign done_o = (cnt_q == CW'(PAT_LEN - 1));

endmodule

// File: rtl/mask_seq_ctrl.sv
// Sequences mask generator reset, pattern load and per-row advance against
// VGA frame/line timing; configuration is kept and replayed every frame.
module mask_seq_ctrl
  import mask_gen_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int PAT_LEN = DEF_PAT_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mask_type,
  input  logic [4:0]         cfg_pattern_w,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic [7:0]         cfg_rep_pattern,
  input  logic               frame_start,
  input  logic               line_req,
  output logic               mg_rst_n,
  output logic               mg_clk_en,
  output logic               mg_load_pattern,
  output logic               mg_pattern,
  output logic [4:0]         mg_pattern_w,
  output logic [7:0]         mg_repeated_pattern,
  output logic [1:0]         mg_mask_type,
  input  logic               mg_rp_valid,
  output logic [8:0]         row_idx,
  output logic               row_valid,
  output logic               frame_done,
  output logic               underrun,
  output logic               busy,
  output logic [2:0]         dbg_state
);

  // Handshake: a configuration transfers on any rising clk edge where
  // cfg_valid && cfg_ready; cfg_ready is high only in IDLE/WAIT_FRAME.

  state_e     state_q, state_d;
  logic       live_q;
  logic [1:0] type_q, type_d;
  logic [4:0] pw_q, pw_d;
  logic [7:0] rep_q, rep_d;
  logic [8:0] row_q, row_d;
  logic       row_valid_q, row_valid_d;
  logic       frame_done_q, frame_done_d;
  logic       underrun_q, underrun_d;

  logic       accept;
  logic       ser_load, ser_shift, ser_bit, ser_done;

  mask_pattern_serializer #(.PAT_LEN(PAT_LEN)) u_ser (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ser_load),
    .data_i  (cfg_pattern),
    .shift_i (ser_shift),
    .bit_o   (ser_bit),
    .done_o  (ser_done)
  );

  // live_q holds the generator in reset and refuses configs until the
  // first clock edge after rst releases.
  assign cfg_ready = live_q && (state_q == IDLE || state_q == WAIT_FRAME);
  assign accept    = cfg_valid && cfg_ready;
  assign mg_rst_n  = live_q && (state_q != GEN_RST);
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_comb begin
    state_d         = state_q;
    type_d          = type_q;
    pw_d            = pw_q;
    rep_d           = rep_q;
    row_d           = row_q;
    row_valid_d     = 1'b0;
    frame_done_d    = 1'b0;
    underrun_d      = underrun_q;
    ser_load        = 1'b0;
    ser_shift       = 1'b0;
    mg_clk_en       = 1'b0;
    mg_load_pattern = 1'b0;
    mg_pattern      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) state_d = GEN_RST;
      end
      GEN_RST: begin
        state_d = LOAD;
      end
      LOAD: begin
        mg_load_pattern = 1'b1;
        if (type_q == REPEAT) begin
          state_d = WAIT_FRAME;
        end else begin
          mg_pattern = ser_bit;
          ser_shift  = 1'b1;
          if (ser_done) state_d = WAIT_FRAME;
        end
      end
      WAIT_FRAME: begin
        if (line_req) underrun_d = 1'b1;
        if (accept) begin
          state_d = GEN_RST;
        end else if (frame_start) begin
          row_d   = '0;
          state_d = ROW_WAIT;
        end
      end
      ROW_WAIT: begin
        if (line_req) state_d = ROW_RUN;
      end
      ROW_RUN: begin
        mg_clk_en = 1'b1;
        if (line_req) underrun_d = 1'b1;
        if (mg_rp_valid) begin
          row_valid_d = 1'b1;
          if (row_q == 9'(ROWS - 1)) begin
            frame_done_d = 1'b1;
            row_d        = '0;
            state_d      = WAIT_FRAME;
          end else begin
            row_d   = row_q + 9'd1;
            state_d = ROW_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh configuration wins over everything else, including a
    // simultaneous line_req that would otherwise flag an underrun.
    if (accept) begin
      type_d     = cfg_mask_type;
      pw_d       = cfg_pattern_w;
      rep_d      = cfg_rep_pattern;
      underrun_d = 1'b0;
      ser_load   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      live_q       <= 1'b0;
      type_q       <= '0;
      pw_q         <= '0;
      rep_q        <= '0;
      row_q        <= '0;
      row_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      live_q       <= 1'b1;
      type_q       <= type_d;
      pw_q         <= pw_d;
      rep_q        <= rep_d;
      row_q        <= row_d;
      row_valid_q  <= row_valid_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign mg_mask_type        = type_q;
  assign mg_pattern_w        = pw_q;
  assign mg_repeated_pattern = rep_q;
  assign row_idx             = row_q;
  assign row_valid           = row_valid_q;
  assign frame_done          = frame_done_q;
  assign underrun            = underrun_q;

endmodule

// File: tb/tb_mask_seq_ctrl.sv
// Directed bench for mask_seq_ctrl: a negedge monitor checks load bits, row
// completions, sticky error and registered config against a queue-based model.
module tb_mask_seq_ctrl;

  localparam int ROWS    = 480;
  localparam int PAT_LEN = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_valid, cfg_ready;
  logic [1:0]         cfg_mask_type;
  logic [4:0]         cfg_pattern_w;
  logic [PAT_LEN-1:0] cfg_pattern;
  logic [7:0]         cfg_rep_pattern;
  logic               frame_start, line_req;
  logic               mg_rst_n, mg_clk_en, mg_load_pattern, mg_pattern;
  logic [4:0]         mg_pattern_w;
  logic [7:0]         mg_repeated_pattern;
  logic [1:0]         mg_mask_type;
  logic               mg_rp_valid;
  logic [8:0]         row_idx;
  logic               row_valid, frame_done, underrun, busy;
  logic [2:0]         dbg_state;

  mask_seq_ctrl #(.ROWS(ROWS), .PAT_LEN(PAT_LEN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cfg_valid           (cfg_valid),
    .cfg_ready           (cfg_ready),
    .cfg_mask_type       (cfg_mask_type),
    .cfg_pattern_w       (cfg_pattern_w),
    .cfg_pattern         (cfg_pattern),
    .cfg_rep_pattern     (cfg_rep_pattern),
    .frame_start         (frame_start),
    .line_req            (line_req),
    .mg_rst_n            (mg_rst_n),
    .mg_clk_en           (mg_clk_en),
    .mg_load_pattern     (mg_load_pattern),
    .mg_pattern          (mg_pattern),
    .mg_pattern_w        (mg_pattern_w),
    .mg_repeated_pattern (mg_repeated_pattern),
    .mg_mask_type        (mg_mask_type),
    .mg_rp_valid         (mg_rp_valid),
    .row_idx             (row_idx),
    .row_valid           (row_valid),
    .frame_done          (frame_done),
    .underrun            (underrun),
    .busy                (busy),
    .dbg_state           (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model state / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int frames_seen = 0;
  int rows_seen = 0;

  logic [1:0] exp_load_q[$];  // {care, bit}
  logic [8:0] exp_row_q[$];   // row_idx shown with each row_valid
  logic [1:0] m_type;
  logic [4:0] m_w;
  logic [7:0] m_rep;
  logic       m_underrun;
  logic [1:0] e_load;
  logic [8:0] e_row;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mg_load_pattern) begin
        if (exp_load_q.size() == 0) chk("load_extra", mg_load_pattern, 1'b0);
        else begin
          e_load = exp_load_q.pop_front();
          if (e_load[1]) chk("load_bit", mg_pattern, e_load[0]);
        end
      end
      if (row_valid) begin
        rows_seen++;
        if (exp_row_q.size() == 0) chk("row_extra", row_valid, 1'b0);
        else begin
          e_row = exp_row_q.pop_front();
          chk("row_idx_at_valid", row_idx, e_row);
        end
      end
      if (frame_done) begin
        frames_seen++;
        chk("frame_done_row", row_idx, 0);
        chk("frame_done_with_valid", row_valid, 1);
      end
      chk("underrun", underrun, m_underrun);
      chk("mg_mask_type", mg_mask_type, m_type);
      chk("mg_pattern_w", mg_pattern_w, m_w);
      chk("mg_rep", mg_repeated_pattern, m_rep);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [1:0] t, input logic [4:0] w, input logic [31:0] pat,
                        input logic [7:0] rep, input bit with_fs, input int exp_loads,
                        output logic [7:0] first_byte);
    int n;
    first_byte = '0;
    if (t == 2'b11) exp_load_q.push_back(2'b00);
    else for (int i = PAT_LEN - 1; i >= 0; i--) exp_load_q.push_back({1'b1, pat[i]});
    chk("cfg_ready_pre", cfg_ready, 1);
    cfg_mask_type = t; cfg_pattern_w = w; cfg_pattern = pat; cfg_rep_pattern = rep;
    cfg_valid = 1'b1; frame_start = with_fs;
    cycle();
    cfg_valid = 1'b0; frame_start = 1'b0;
    m_type = t; m_w = w; m_rep = rep; m_underrun = 1'b0;
    chk("gen_rst_low", mg_rst_n, 0);
    chk("gen_rst_busy", busy, 1);
    chk("gen_rst_not_ready", cfg_ready, 0);
    cycle();
    chk("gen_rst_one_cycle", mg_rst_n, 1);
    n = 0;
    while (mg_load_pattern === 1'b1 && n < PAT_LEN + 8) begin
      if (n < 8) first_byte = {first_byte[6:0], mg_pattern};
      n++;
      cycle();
    end
    chk("load_cycles", n, exp_loads);
    chk("load_drained", exp_load_q.size(), 0);
    chk("wait_frame_ready", cfg_ready, 1);
    chk("wait_frame_busy", busy, 1);
  endtask

  // Each row: line_req, generator answers mg_rp_valid two cycles later.
  task automatic run_rows(input int first, input int count);
    for (int r = first; r < first + count; r++) begin
      exp_row_q.push_back(9'((r + 1) % ROWS));
      line_req = 1'b1;
      cycle();
      line_req = 1'b0;
      chk("row_idx_run", row_idx, r);
      chk("clk_en_run", mg_clk_en, 1);
      cycle();
      mg_rp_valid = 1'b1;
      cycle();
      mg_rp_valid = 1'b0;
      chk("clk_en_drop", mg_clk_en, 0);
      chk("row_valid_pulse", row_valid, 1);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] fb;

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_mask_type = '0; cfg_pattern_w = '0; cfg_pattern = '0;
    cfg_rep_pattern = '0; frame_start = 1'b0; line_req = 1'b0; mg_rp_valid = 1'b0;
    m_type = '0; m_w = '0; m_rep = '0; m_underrun = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mg_rst_n", mg_rst_n, 0);
    chk("rst_cfg_ready", cfg_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clk_en", mg_clk_en, 0);
    chk("rst_load", mg_load_pattern, 0);
    chk("rst_pattern", mg_pattern, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_row_valid", row_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_cfg_regs", {mg_mask_type, mg_pattern_w, mg_repeated_pattern}, 0);
    rst = 1'b0;
    cycle();
    chk("post_rst_cfg_ready", cfg_ready, 1);
    chk("post_rst_mg_rst_n", mg_rst_n, 1);
    chk("post_rst_busy", busy, 0);

    // Slide-right config: first eight serial bits are 0000_0011.
    do_cfg(2'b00, 5'd20, 32'h03D0A052, 8'h5A, 1'b0, 32, fb);
    chk("first_byte_03", fb, 8'h03);

    // One complete frame of 480 rows.
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("frame_row0", row_idx, 0);
    chk("row_wait_not_ready", cfg_ready, 0);
    run_rows(0, ROWS);
    cycle();
    chk("frames_after_1", frames_seen, 1);
    chk("rows_after_1", rows_seen, 480);
    chk("row_idx_wrapped", row_idx, 0);
    chk("back_to_wait_frame", cfg_ready, 1);

    // Repeated-pattern config from WAIT_FRAME: one load strobe.
    do_cfg(2'b11, 5'd8, 32'h0, 8'hAF, 1'b0, 1, fb);
    chk("rep_af", mg_repeated_pattern, 8'hAF);
    chk("type_11", mg_mask_type, 2'b11);

    // Extra line_req during ROW_RUN flags underrun, row still counted once.
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    exp_row_q.push_back(9'd1);
    line_req = 1'b1;
    cycle();
    cycle();
    line_req = 1'b0;
    m_underrun = 1'b1;
    chk("underrun_set", underrun, 1);
    mg_rp_valid = 1'b1;
    cycle();
    mg_rp_valid = 1'b0;
    chk("underrun_row_valid", row_valid, 1);
    chk("underrun_row_idx", row_idx, 1);
    run_rows(1, 9);

    // frame_start mid-frame is ignored.
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    chk("fs_ignored_row", row_idx, 10);
    chk("fs_ignored_ready", cfg_ready, 0);
    run_rows(10, 190);
    chk("at_row_200", row_idx, 200);

    // Reset in the middle of row 200.
    line_req = 1'b1;
    cycle();
    line_req = 1'b0;
    chk("row200_running", mg_clk_en, 1);
    #2 rst = 1'b1;
    #1;
    m_type = '0; m_w = '0; m_rep = '0; m_underrun = 1'b0;
    exp_load_q.delete();
    exp_row_q.delete();
    chk("midrst_busy", busy, 0);
    chk("midrst_clk_en", mg_clk_en, 0);
    chk("midrst_mg_rst_n", mg_rst_n, 0);
    chk("midrst_ready", cfg_ready, 0);
    chk("midrst_row_idx", row_idx, 0);
    chk("midrst_underrun", underrun, 0);
    chk("midrst_cfg_regs", {mg_mask_type, mg_pattern_w, mg_repeated_pattern}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    chk("midrst_no_frame_done", frames_seen, 1);
    chk("midrst_ready_again", cfg_ready, 1);

    // Fresh full reload after reset.
    do_cfg(2'b01, 5'd31, 32'hA5C30F81, 8'h3C, 1'b0, 32, fb);
    chk("first_byte_a5", fb, 8'hA5);

    // line_req in WAIT_FRAME is an underrun.
    line_req = 1'b1;
    cycle();
    line_req = 1'b0;
    m_underrun = 1'b1;
    chk("wf_underrun", underrun, 1);
    chk("wf_still_ready", cfg_ready, 1);

    // cfg_valid and frame_start together: config wins.
    do_cfg(2'b10, 5'd9, 32'h80000001, 8'h11, 1'b1, 32, fb);
    chk("first_byte_80", fb, 8'h80);
    chk("cfg_clears_underrun", underrun, 0);
    chk("simul_row_idx", row_idx, 0);

    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    run_rows(0, 2);
    chk("new_frame_rows", row_idx, 2);
    cycle();
    chk("final_frames", frames_seen, 1);
    chk("final_rows_drained", exp_row_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
